// File: rtl/agc_level_detector_if.sv
// Sample/decision bundle between the ADC stream, the AGC level detector and the gain search block.
// The fail signal exists only when AGC_STEP_LIMIT_EN is defined.
interface agc_level_detector_if #(
  parameter int DATA_W = 8
);
  logic                     start;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample;
  logic                     search_done;
  logic                     adjust;
  logic                     up_dn;
  logic                     busy;
  logic                     locked;
  logic [DATA_W-2:0]        peak;
`ifdef AGC_STEP_LIMIT_EN
  logic                     fail;
`endif

  modport master (
    output start, sample_valid, sample, search_done,
`ifdef AGC_STEP_LIMIT_EN
    input  fail,
`endif
    input  adjust, up_dn, busy, locked, peak
  );

  modport slave (
    input  start, sample_valid, sample, search_done,
`ifdef AGC_STEP_LIMIT_EN
    output fail,
`endif
    output adjust, up_dn, busy, locked, peak
  );
endinterface

// File: rtl/agc_level_detector.sv
// AGC level detector: settle, measure window peak |sample|, issue one adjust/up_dn per step until search_done.
// Optional step limit with fail output: define AGC_STEP_LIMIT_EN.
module agc_level_detector #(
  parameter int DATA_W        = 8,
  parameter int WINDOW        = 64,
  parameter int SETTLE_CYCLES = 16,
  parameter int TARGET        = 96
) (
  input  logic                       clk,
  input  logic                       RESETn,
  agc_level_detector_if.slave        bus
);

  localparam int MW = DATA_W - 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] WINDOW_LAST = WW'(WINDOW - 1);
  localparam logic [MW-1:0] TARGET_M    = MW'(TARGET);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_MEASURE, ST_DECIDE, ST_ADJUST, ST_CHECK, ST_LOCKED, ST_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [MW-1:0] max_q, max_d;
  logic [MW-1:0] peak_q, peak_d;
  logic          adjust_q, adjust_d;
  logic          up_dn_q, up_dn_d;
  logic          busy_q, busy_d;
  logic          locked_q, locked_d;
`ifdef AGC_STEP_LIMIT_EN
  logic [3:0]    adj_cnt_q, adj_cnt_d;
  logic          fail_q, fail_d;
`endif

  logic [DATA_W-1:0] neg_sample;
  logic [MW-1:0]     mag;
  logic [MW-1:0]     new_max;

  // The most negative code has no positive twin; it saturates to the largest magnitude.
  always_comb begin
    neg_sample = -bus.sample;
    if (!bus.sample[DATA_W-1])         mag = bus.sample[MW-1:0];
    else if (bus.sample[MW-1:0] == '0) mag = '1;
    else                               mag = neg_sample[MW-1:0];
    new_max = (mag > max_q) ? mag : max_q;
  end

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    max_d        = max_q;
    peak_d       = peak_q;
    up_dn_d      = up_dn_q;
`ifdef AGC_STEP_LIMIT_EN
    adj_cnt_d    = adj_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d   = ST_MEASURE;
          max_d     = '0;
          win_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (bus.sample_valid) begin
          if (win_cnt_q == WINDOW_LAST) begin
            peak_d  = new_max;
            state_d = ST_DECIDE;
          end else begin
            max_d     = new_max;
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end
      end
      ST_DECIDE: begin
        up_dn_d = (peak_q <= TARGET_M);
        state_d = ST_ADJUST;
`ifdef AGC_STEP_LIMIT_EN
        adj_cnt_d = adj_cnt_q + 1'b1;
`endif
      end
      ST_ADJUST: state_d = ST_CHECK;
      // The gain block's pointer moved at the end of ADJUST, so search_done is valid here.
      ST_CHECK: begin
        if (bus.search_done) begin
          state_d = ST_LOCKED;
`ifdef AGC_STEP_LIMIT_EN
        end else if (adj_cnt_q == 4'd8) begin
          state_d = ST_FAIL;
`endif
        end else begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
      end
      ST_LOCKED: state_d = ST_LOCKED;
      ST_FAIL:   state_d = ST_FAIL;
      default:   state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies decoded from the next state.
    adjust_d = (state_d == ST_ADJUST);
    busy_d   = !(state_d inside {ST_IDLE, ST_LOCKED, ST_FAIL});
    locked_d = (state_d == ST_LOCKED);
`ifdef AGC_STEP_LIMIT_EN
    fail_d   = (state_d == ST_FAIL);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      max_q        <= '0;
      peak_q       <= '0;
      adjust_q     <= 1'b0;
      up_dn_q      <= 1'b0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
`ifdef AGC_STEP_LIMIT_EN
      adj_cnt_q    <= '0;
      fail_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      max_q        <= max_d;
      peak_q       <= peak_d;
      adjust_q     <= adjust_d;
      up_dn_q      <= up_dn_d;
      busy_q       <= busy_d;
      locked_q     <= locked_d;
`ifdef AGC_STEP_LIMIT_EN
      adj_cnt_q    <= adj_cnt_d;
      fail_q       <= fail_d;
`endif
    end
  end

  assign bus.adjust = adjust_q;
  assign bus.up_dn  = up_dn_q;
  assign bus.busy   = busy_q;
  assign bus.locked = locked_q;
  assign bus.peak   = peak_q;
`ifdef AGC_STEP_LIMIT_EN
  assign bus.fail   = fail_q;
`endif

endmodule

// File: tb/tb_agc_level_detector.sv
// Directed bench for agc_level_detector with a 6-step binary gain search model.
// Covers the AGC_STEP_LIMIT_EN build as well when that macro is defined.
module tb_agc_level_detector;

  logic clk = 1'b0;
  logic RESETn;
  always #5 clk = ~clk;

  agc_level_detector_if #(.DATA_W(8)) bus ();

  agc_level_detector #(
    .DATA_W(8), .WINDOW(64), .SETTLE_CYCLES(16), .TARGET(96)
  ) dut (
    .clk    (clk),
    .RESETn (RESETn),
    .bus    (bus.slave)
  );

  // Gain search model: six halving steps, done once the bit pointer reaches zero.
  int   bit_idx;
  logic model_stuck = 1'b0;
  always @(posedge clk) begin
    if (!RESETn)                   bit_idx <= 6;
    else if (bus.adjust && bit_idx > 0) bit_idx <= bit_idx - 1;
  end
  assign bus.search_done = !model_stuck && (bit_idx == 0);

  // Pulse monitor sampled on the falling edge.
  int cyc = 0;
  int pulse_cnt, up_cnt, width_bad, interval_bad, first_pulse_cyc, last_pulse_cyc;
  logic prev_adj;
  always @(negedge clk) begin
    if (!RESETn) begin
      pulse_cnt = 0; up_cnt = 0; width_bad = 0; interval_bad = 0;
      first_pulse_cyc = -1; last_pulse_cyc = 0; prev_adj = 1'b0;
    end else begin
      if (bus.adjust) begin
        if (prev_adj) width_bad++;
        if (pulse_cnt > 0 && (cyc - last_pulse_cyc) != 83) interval_bad++;
        if (pulse_cnt == 0) first_pulse_cyc = cyc;
        last_pulse_cyc = cyc;
        pulse_cnt++;
        if (bus.up_dn) up_cnt++;
      end
      prev_adj = bus.adjust;
    end
    cyc++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_start();
    RESETn = 1'b0; bus.start = 1'b0; bus.sample_valid = 1'b0; bus.sample = '0;
    tick();
    RESETn = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // 16 settle cycles (optionally with decoy 127 samples), then 64 valid samples alternating a/b.
  task automatic settle_and_measure(input logic signed [7:0] a, input logic signed [7:0] b,
                                    input bit decoy);
    bus.sample_valid = decoy; bus.sample = 8'sd127;
    repeat (16) tick();
    for (int i = 0; i < 64; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample = (i % 2 == 0) ? a : b;
      tick();
    end
    bus.sample_valid = 1'b0;
  endtask

  int t0;

  initial begin
    RESETn = 1'b0; bus.start = 1'b1; bus.sample_valid = 1'b0; bus.sample = '0;
    tick(); tick();
    check("rst_adjust", int'(bus.adjust), 0);
    check("rst_up_dn",  int'(bus.up_dn),  0);
    check("rst_busy",   int'(bus.busy),   0);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_peak",   int'(bus.peak),   0);
`ifdef AGC_STEP_LIMIT_EN
    check("rst_fail",   int'(bus.fail),   0);
`endif

    // Full acquisition at +120 with decoy 127 samples during the first settle.
    RESETn = 1'b1;
    tick();
    check("busy_after_start", int'(bus.busy), 1);
    t0 = cyc;
    bus.start = 1'b0;
    bus.sample_valid = 1'b1; bus.sample = 8'sd127;
    repeat (16) tick();
    bus.sample = 8'sd120;
    for (int i = 0; i < 600 && !bus.locked; i++) tick();
    check("lock_reached",     int'(bus.locked), 1);
    check("first_pulse_lat",  first_pulse_cyc - t0, 81);
    check("pulse_count",      pulse_cnt, 6);
    check("pulse_up_count",   up_cnt, 0);
    check("pulse_width",      width_bad, 0);
    check("pulse_interval",   interval_bad, 0);
    check("peak_120",         int'(bus.peak), 120);
    check("locked_busy",      int'(bus.busy), 0);
    bus.start = 1'b1;
    repeat (3) tick();
    bus.start = 1'b0;
    check("locked_ignores_start_busy",   int'(bus.busy), 0);
    check("locked_ignores_start_locked", int'(bus.locked), 1);
    check("locked_no_adjust",            pulse_cnt, 6);

    // Alternating +50/-100.
    do_reset_start();
    settle_and_measure(8'sd50, -8'sd100, 1'b0);
    check("alt_decide_no_adj", int'(bus.adjust), 0);
    tick();
    check("alt_adjust", int'(bus.adjust), 1);
    check("alt_peak",   int'(bus.peak), 100);
    check("alt_up_dn",  int'(bus.up_dn), 0);

    // Most negative code saturates.
    do_reset_start();
    settle_and_measure(-8'sd128, -8'sd128, 1'b0);
    tick();
    check("neg_adjust", int'(bus.adjust), 1);
    check("neg_peak",   int'(bus.peak), 127);
    check("neg_up_dn",  int'(bus.up_dn), 0);

    // Peak exactly at target means increase.
    do_reset_start();
    settle_and_measure(8'sd96, 8'sd96, 1'b0);
    tick();
    check("tgt_adjust", int'(bus.adjust), 1);
    check("tgt_peak",   int'(bus.peak), 96);
    check("tgt_up_dn",  int'(bus.up_dn), 1);

    // Sparse valid (every 3rd cycle) with spike on the 64th valid sample.
    do_reset_start();
    bus.sample_valid = 1'b1; bus.sample = 8'sd127;
    repeat (16) tick();
    for (int i = 0; i < 192; i++) begin
      bus.sample_valid = (i % 3 == 2);
      bus.sample = (i == 191) ? 8'sd110 : 8'sd20;
      tick();
      if (i == 188) check("sparse_no_early_adj", pulse_cnt, 0);
    end
    bus.sample_valid = 1'b0;
    check("sparse_decide_no_adj", int'(bus.adjust), 0);
    tick();
    check("sparse_adjust", int'(bus.adjust), 1);
    check("sparse_peak",   int'(bus.peak), 110);
    check("sparse_up_dn",  int'(bus.up_dn), 0);

    // Reset during MEASURE.
    do_reset_start();
    repeat (16) tick();
    bus.sample_valid = 1'b1; bus.sample = 8'sd90;
    repeat (30) tick();
    RESETn = 1'b0;
    tick();
    check("rst_meas_adjust", int'(bus.adjust), 0);
    check("rst_meas_busy",   int'(bus.busy), 0);
    check("rst_meas_peak",   int'(bus.peak), 0);
    RESETn = 1'b1;
    repeat (60) tick();
    check("rst_meas_idle_busy", int'(bus.busy), 0);
    check("rst_meas_no_pulse",  pulse_cnt, 0);

    // Reset in the DECIDE cycle: no pulse may leak out.
    do_reset_start();
    settle_and_measure(8'sd30, 8'sd30, 1'b0);
    RESETn = 1'b0;
    tick();
    check("rst_decide_adjust", int'(bus.adjust), 0);
    RESETn = 1'b1;
    tick();
    check("rst_decide_after", int'(bus.adjust), 0);

    // Reset in the ADJUST cycle.
    do_reset_start();
    settle_and_measure(8'sd30, 8'sd30, 1'b0);
    tick();
    check("pre_rst_adjust", int'(bus.adjust), 1);
    RESETn = 1'b0;
    tick();
    check("rst_adj_adjust", int'(bus.adjust), 0);
    check("rst_adj_up_dn",  int'(bus.up_dn), 0);
    check("rst_adj_busy",   int'(bus.busy), 0);
    RESETn = 1'b1;
    repeat (3) tick();
    check("rst_adj_after", int'(bus.adjust), 0);

    // Restart: full settle applied again (decoy 127 must be ignored).
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    settle_and_measure(8'sd10, 8'sd10, 1'b1);
    tick();
    check("restart_adjust", int'(bus.adjust), 1);
    check("restart_peak",   int'(bus.peak), 10);
    check("restart_up_dn",  int'(bus.up_dn), 1);

    // Gain block stuck at maximum: search_done never asserts.
    model_stuck = 1'b1;
    do_reset_start();
    bus.sample_valid = 1'b1; bus.sample = 8'sd10;
`ifdef AGC_STEP_LIMIT_EN
    for (int i = 0; i < 900 && !bus.fail; i++) tick();
    check("stuck_fail",   int'(bus.fail), 1);
    check("stuck_pulses", pulse_cnt, 8);
    check("stuck_ups",    up_cnt, 8);
    check("stuck_busy",   int'(bus.busy), 0);
    check("stuck_locked", int'(bus.locked), 0);
`else
    repeat (840) tick();
    check("stuck_pulses",   pulse_cnt, 10);
    check("stuck_ups",      up_cnt, 10);
    check("stuck_interval", interval_bad, 0);
    check("stuck_busy",     int'(bus.busy), 1);
    check("stuck_locked",   int'(bus.locked), 0);
`endif
    model_stuck = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/agc_level_detector.md
Name: agc_level_detector

Overview:
- Upstream stage of the AGC gain binary search block: measures received ADC sample magnitude over a fixed window after each gain change.
- Issues one adjust/up_dn decision per step to the gain search block and stops when that block reports done.
- Sits between the ADC sample stream and the gain search block; RESETn is shared with the gain search block, so both start a fresh acquisition together.

Parameters:
- DATA_W, 8, ADC sample width (signed two's complement).
- WINDOW, 64, number of valid samples per peak measurement (>=1).
- SETTLE_CYCLES, 16, clk cycles waited after each gain change before measuring (>=1).
- TARGET, 96, peak magnitude threshold: peak > TARGET means decrease gain, otherwise increase gain.

Ports:
- clk  input  1  clock
- RESETn  input  1  reset, synchronous, active-low
- start  input  1  begin acquisition; sampled only in IDLE
- sample_valid  input  1  qualifies sample
- sample  input  DATA_W  signed ADC sample
- search_done  input  1  done from gain search block (combinational from its pointer)
- adjust  output  1  one-cycle decision pulse to gain search block
- up_dn  output  1  1 = increase gain, 0 = decrease; valid whenever adjust=1
- busy  output  1  high in every state except IDLE, LOCKED, FAIL
- locked  output  1  search completed
- peak  output  DATA_W-1  last completed window peak magnitude

Behaviour:
- Reset (RESETn=0 at posedge): state=IDLE, adjust=0, up_dn=0, busy=0, locked=0, peak=0, window counter=0, settle counter=0, running max=0. Reset mid-acquisition aborts immediately; no adjust is issued in the reset cycle.
- All outputs are registered.
- Magnitude: |sample|; the most negative code (-2^(DATA_W-1)) saturates to 2^(DATA_W-1)-1. Width is DATA_W-1.
- States:
  - IDLE: start=1 -> SETTLE with settle counter=0.
  - SETTLE: counts SETTLE_CYCLES clk cycles regardless of sample_valid, then -> MEASURE with running max=0 and window count=0. Samples arriving during SETTLE are ignored.
  - MEASURE: on each sample_valid, running max = max(running max, magnitude) and count increments. When the WINDOW-th valid sample is accepted, peak loads the final max (including that sample) -> DECIDE.
  - DECIDE: 1 cycle. up_dn <= (peak <= TARGET); adjust <= 1 -> ADJUST.
  - ADJUST: adjust is high for exactly this cycle and is deasserted on exit -> CHECK.
  - CHECK: 1 cycle; search_done is sampled here (the gain block updates at the end of the ADJUST cycle). search_done=1 -> LOCKED; else -> SETTLE.
  - LOCKED: locked=1, busy=0, terminal; start is ignored. Only RESETn leaves this state.
- search_done is ignored in every state except CHECK.
- Exactly one adjust pulse per measurement window; adjust never asserts in consecutive cycles.
- Nominal acquisition (no saturation at max gain): 6 adjust pulses, then LOCKED.
- Boundary: peak == TARGET counts as increase (up_dn=1). sample_valid held high for the whole window: one sample per cycle, WINDOW cycles in MEASURE.

Optional Feature:
- Macro AGC_STEP_LIMIT_EN.
- Defined: an adjust counter (4 bits, cleared at reset) increments on each adjust pulse. If CHECK sees search_done=0 and the count equals 8, go to FAIL: busy=0, locked=0, fail=1, terminal until reset. Adds output port fail (1 bit, reset 0). This covers the case where the gain search block ignores increase requests at maximum gain, so search_done never asserts.
- Not defined: no fail port, no counter; the CHECK -> SETTLE loop repeats indefinitely.

Test Plan:
- Reset with start=1 held -> all outputs 0, state IDLE. Release reset -> busy=1 on the next cycle; the first sample is accepted only after 16 settle cycles.
- Constant samples of +120 (> TARGET), gain-search model attached -> 6 adjust pulses all with up_dn=0, each pulse 1 cycle wide, 16+64+3 cycles apart. locked=1 after the 6th pulse; peak=120.
- Alternating samples +50/-100 -> peak=100, up_dn=0. Samples of -128 -> peak=127. Samples of exactly +96 -> up_dn=1.
- sample_valid toggled every 3rd cycle -> exactly 64 valid samples per window. A spike of 110 on the 64th valid sample is included in peak. Samples during SETTLE do not affect peak.
- Assert RESETn=0 during MEASURE and during the ADJUST cycle -> adjust=0 in the reset cycle and after. Restart with start -> full 16-cycle settle is applied again.
- With AGC_STEP_LIMIT_EN defined: constant samples of +10 and a gain model stuck at maximum with search_done=0 -> 8 pulses with up_dn=1, then fail=1, busy=0, locked=0. Without the macro: pulses continue past 8.
